// File: rtl/rx_comma_aligner.sv
// K28.5 comma aligner: slices the equalizer output, finds 10-bit word alignment,
// emits aligned code groups and tracks lock (misaligned-comma realign, comma timeout).
module rx_comma_aligner #(
    parameter real THRESH         = 0.5,
    parameter int  REALIGN_THRESH = 3,
    parameter int  TIMEOUT_WORDS  = 1024,
    parameter int  TO_W           = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  real        data_in,
    input  logic       realign_req,
    output logic [9:0] word_out,
    output logic       word_valid,
    output logic       comma_det,
    output logic       locked,
    output logic       realign_evt
);

    localparam int              MA_W      = (REALIGN_THRESH > 1) ? $clog2(REALIGN_THRESH + 1) : 1;
    localparam logic [9:0]      K28_5_RDN = 10'h17C;
    localparam logic [9:0]      K28_5_RDP = 10'h283;
    localparam logic [3:0]      LAST_BIT  = 4'd9;
    localparam logic [MA_W-1:0] MA_LIMIT  = MA_W'(REALIGN_THRESH);
    localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_WORDS);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    function automatic logic is_comma(input logic [9:0] w);
        return (w == K28_5_RDN) || (w == K28_5_RDP);
    endfunction

    state_t          r_state;
    logic [9:0]      r_sr;
    logic [3:0]      r_bit_cnt;
    logic [MA_W-1:0] r_misalign_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic [9:0]      r_word_out;
    logic            r_word_valid;
    logic            r_comma_det;
    logic            r_locked;
    logic            r_realign_evt;

    logic            w_bit;
    logic [9:0]      w_sr_next;
    logic            w_match;
    logic            w_boundary;
    logic [MA_W-1:0] w_misalign_inc;
    logic [TO_W-1:0] w_to_inc;

    // The incoming bit enters at bit9 so the first-received bit ends up in bit0 ('a').
    assign w_bit          = (data_in > THRESH);
    assign w_sr_next      = {w_bit, r_sr[9:1]};
    assign w_match        = is_comma(w_sr_next);
    assign w_boundary     = (r_bit_cnt == LAST_BIT);
    assign w_misalign_inc = r_misalign_cnt + MA_W'(1);
    assign w_to_inc       = r_to_cnt + TO_W'(1);

    // Alignment FSM with shift register, phase/misalign/timeout counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_SEARCH;
            r_sr           <= 10'd0;
            r_bit_cnt      <= 4'd0;
            r_misalign_cnt <= '0;
            r_to_cnt       <= '0;
            r_word_out     <= 10'd0;
            r_word_valid   <= 1'b0;
            r_comma_det    <= 1'b0;
            r_locked       <= 1'b0;
            r_realign_evt  <= 1'b0;
        end else begin
            r_sr          <= w_sr_next;
            r_word_valid  <= 1'b0;
            r_comma_det   <= 1'b0;
            r_realign_evt <= 1'b0;
            if (realign_req) begin
                r_state        <= ST_SEARCH;
                r_locked       <= 1'b0;
                r_bit_cnt      <= 4'd0;
                r_misalign_cnt <= '0;
                r_to_cnt       <= '0;
            end else begin
                case (r_state)
                    ST_SEARCH: begin
                        if (w_match) begin
                            r_word_out     <= w_sr_next;
                            r_word_valid   <= 1'b1;
                            r_comma_det    <= 1'b1;
                            r_bit_cnt      <= 4'd0;
                            r_to_cnt       <= '0;
                            r_misalign_cnt <= '0;
                            r_state        <= ST_LOCKED;
                            r_locked       <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_boundary) begin
                            r_word_out   <= w_sr_next;
                            r_word_valid <= 1'b1;
                            r_bit_cnt    <= 4'd0;
                            if (w_match) begin
                                r_comma_det    <= 1'b1;
                                r_to_cnt       <= '0;
                                r_misalign_cnt <= '0;
                            end else if (w_to_inc == TO_LIMIT) begin
                                // Too long without an in-phase comma: this word still goes out.
                                r_state        <= ST_SEARCH;
                                r_locked       <= 1'b0;
                                r_to_cnt       <= '0;
                                r_misalign_cnt <= '0;
                            end else begin
                                r_to_cnt <= w_to_inc;
                            end
                        end else if (w_match) begin
                            if (w_misalign_inc == MA_LIMIT) begin
                                r_bit_cnt      <= 4'd0;
                                r_word_out     <= w_sr_next;
                                r_word_valid   <= 1'b1;
                                r_comma_det    <= 1'b1;
                                r_realign_evt  <= 1'b1;
                                r_misalign_cnt <= '0;
                                r_to_cnt       <= '0;
                            end else begin
                                r_misalign_cnt <= w_misalign_inc;
                                r_bit_cnt      <= r_bit_cnt + 4'd1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    default: begin
                        r_state  <= ST_SEARCH;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign word_out    = r_word_out;
    assign word_valid  = r_word_valid;
    assign comma_det   = r_comma_det;
    assign locked      = r_locked;
    assign realign_evt = r_realign_evt;

endmodule

// File: tb/tb_rx_comma_aligner.sv
// Directed bench for rx_comma_aligner: acquire, slicing, re-align, timeout, reset and priority.
module tb_rx_comma_aligner;

    logic       clk;
    logic       rst_n;
    real        data_in;
    logic       realign_req;
    logic [9:0] word_out;
    logic       word_valid;
    logic       comma_det;
    logic       locked;
    logic       realign_evt;

    int n_checks = 0;
    int n_errors = 0;
    int vcnt     = 0;
    int vbase;

    localparam logic [9:0] K_RDN = 10'h17C;
    localparam logic [9:0] K_RDP = 10'h283;
    localparam logic [9:0] D215  = 10'h155;

    rx_comma_aligner dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .realign_req (realign_req),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .comma_det   (comma_det),
        .locked      (locked),
        .realign_evt (realign_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one level on the falling edge, then look at the outputs just after the rising edge.
    task automatic send_lvl(input real v, input logic req);
        @(negedge clk);
        data_in     = v;
        realign_req = req;
        @(posedge clk);
        #1;
        if (word_valid) vcnt++;
    endtask

    task automatic send_bit(input logic b);
        send_lvl(b ? 0.9 : 0.1, 1'b0);
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) send_bit(w[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        data_in     = 0.0;
        realign_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_word_out", 32'(word_out), 32'h0);
        check_eq("rst_valid", 32'(word_valid), 32'h0);
        check_eq("rst_locked", 32'(locked), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle alternating pattern never contains a comma.
        vbase = vcnt;
        for (int i = 0; i < 200; i++) send_bit(i[0]);
        check_eq("idle_valid_cnt", 32'(vcnt - vbase), 32'h0);
        check_eq("idle_locked", 32'(locked), 32'h0);

        // Acquire on K28.5 RD-.
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_word(K_RDN);
        check_eq("acq_valid", 32'(word_valid), 32'h1);
        check_eq("acq_word", 32'(word_out), 32'(K_RDN));
        check_eq("acq_comma", 32'(comma_det), 32'h1);
        check_eq("acq_locked", 32'(locked), 32'h1);
        for (int i = 0; i < 9; i++) send_bit(D215[i]);
        check_eq("acq_mid_valid", 32'(word_valid), 32'h0);
        send_bit(D215[9]);
        check_eq("d215_valid", 32'(word_valid), 32'h1);
        check_eq("d215_word", 32'(word_out), 32'(D215));
        check_eq("d215_comma", 32'(comma_det), 32'h0);

        // Re-align after a 3-bit slip.
        send_word(D215);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_word(K_RDN);
        check_eq("mis1_valid", 32'(word_valid), 32'h0);
        check_eq("mis1_evt", 32'(realign_evt), 32'h0);
        send_word(K_RDN);
        check_eq("mis2_valid", 32'(word_valid), 32'h0);
        send_word(K_RDN);
        check_eq("mis3_valid", 32'(word_valid), 32'h1);
        check_eq("mis3_evt", 32'(realign_evt), 32'h1);
        check_eq("mis3_word", 32'(word_out), 32'(K_RDN));
        check_eq("mis3_comma", 32'(comma_det), 32'h1);
        check_eq("mis3_locked", 32'(locked), 32'h1);
        send_word(D215);
        check_eq("new_phase_valid", 32'(word_valid), 32'h1);
        check_eq("new_phase_word", 32'(word_out), 32'(D215));
        check_eq("new_phase_evt", 32'(realign_evt), 32'h0);

        // realign_req wins over a boundary comma.
        for (int i = 0; i < 9; i++) send_bit(K_RDN[i]);
        send_lvl(K_RDN[9] ? 0.9 : 0.1, 1'b1);
        check_eq("req_valid", 32'(word_valid), 32'h0);
        check_eq("req_comma", 32'(comma_det), 32'h0);
        send_bit(D215[0]);
        check_eq("req_locked", 32'(locked), 32'h0);
        vbase = vcnt;
        for (int i = 1; i < 10; i++) send_bit(D215[i]);
        send_word(D215);
        send_word(D215);
        check_eq("req_no_words", 32'(vcnt - vbase), 32'h0);

        // Slicing right around the threshold: RD+ comma.
        begin
            logic [9:0] w;
            w = K_RDP;
            for (int i = 0; i < 10; i++) send_lvl(w[i] ? 0.51 : 0.49, 1'b0);
        end
        check_eq("slice_valid", 32'(word_valid), 32'h1);
        check_eq("slice_word", 32'(word_out), 32'(K_RDP));
        check_eq("slice_comma", 32'(comma_det), 32'h1);
        check_eq("slice_locked", 32'(locked), 32'h1);

        // Timeout after 1024 words without an in-phase comma.
        vbase = vcnt;
        for (int i = 0; i < 1023; i++) send_word(D215);
        check_eq("to_words_1023", 32'(vcnt - vbase), 32'd1023);
        check_eq("to_locked_1023", 32'(locked), 32'h1);
        send_word(D215);
        check_eq("to_valid_1024", 32'(word_valid), 32'h1);
        check_eq("to_word_1024", 32'(word_out), 32'(D215));
        send_bit(D215[0]);
        check_eq("to_locked_after", 32'(locked), 32'h0);
        check_eq("to_valid_after", 32'(word_valid), 32'h0);
        vbase = vcnt;
        for (int i = 1; i < 10; i++) send_bit(D215[i]);
        for (int i = 0; i < 5; i++) send_word(D215);
        check_eq("to_no_words", 32'(vcnt - vbase), 32'h0);

        // Async reset mid-word.
        send_word(K_RDN);
        check_eq("relock_locked", 32'(locked), 32'h1);
        send_word(D215);
        check_eq("prerst_word", 32'(word_out), 32'(D215));
        for (int i = 0; i < 4; i++) send_bit(D215[i]);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_word", 32'(word_out), 32'h0);
        check_eq("midrst_valid", 32'(word_valid), 32'h0);
        check_eq("midrst_locked", 32'(locked), 32'h0);
        check_eq("midrst_comma", 32'(comma_det), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        vbase = vcnt;
        for (int i = 4; i < 10; i++) send_bit(D215[i]);
        send_word(D215);
        send_word(D215);
        check_eq("postrst_no_words", 32'(vcnt - vbase), 32'h0);
        check_eq("postrst_locked", 32'(locked), 32'h0);
        send_word(K_RDN);
        check_eq("postrst_acq_valid", 32'(word_valid), 32'h1);
        check_eq("postrst_acq_word", 32'(word_out), 32'(K_RDN));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
